hack_memory_map: RTL and testbench
==================================

# hack_memory_map

Parametrised memory-map controller between the Hack CPU and its RAM, screen and keyboard devices. Decodes CPU addresses into device selects, steers write strobes, and returns registered read data. Adds a keyboard scancode FIFO mode (pop-on-read with status and overflow) and an unmapped-access error flag, alongside the original level-held keyboard behaviour. Sits at the computer top level, in place of the former dmux/mux decode.

## Interface
- DATA_WIDTH, 16, CPU/device data width
- RAM_ADDR_BITS, 14, RAM word address width; RAM occupies 0 .. 2^RAM_ADDR_BITS-1
- SCREEN_ADDR_BITS, 13, screen word address width; screen base = 2^RAM_ADDR_BITS
- KBD_FIFO_DEPTH, 8, scancode FIFO entries; power of two, >= 2
- KBD_MODE, 0, 0 = level (Hack-compatible), 1 = FIFO
- clock  in  1  single system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- cpu_address  in  16  CPU word address (addressM)
- cpu_write_data  in  DATA_WIDTH  CPU store data
- cpu_write  in  1  store strobe (writeM)
- cpu_read  in  1  load request strobe
- cpu_read_data  out  DATA_WIDTH  registered load data
- cpu_read_valid  out  1  one-cycle pulse, cpu_read_data valid
- ram_address  out  RAM_ADDR_BITS  low bits of cpu_address
- ram_write_data, screen_write_data  out  DATA_WIDTH  = cpu_write_data
- ram_write, screen_write  out  1  decoded store strobes
- ram_read_data, screen_read_data  in  DATA_WIDTH  device data, one cycle after address
- screen_address  out  SCREEN_ADDR_BITS  low bits of cpu_address
- kbd_scancode  in  16  scancode from keyboard interface
- kbd_valid  in  1  one-cycle strobe, kbd_scancode new
- kbd_overflow  out  1  sticky FIFO overflow flag
- bus_error  out  1  one-cycle pulse on unmapped or illegal access

## Operation
- Decode: KBD = SCREEN_BASE + 2^SCREEN_ADDR_BITS (0x6000 default). RAM: addr < SCREEN_BASE. SCREEN: SCREEN_BASE <= addr < KBD. KBD_DATA: addr == KBD. KBD_STATUS: addr == KBD+1 (FIFO mode only). All else unmapped.
- ram_write = cpu_write & RAM; screen_write = cpu_write & SCREEN; combinational, device captures on same edge.
- Read: cpu_read latches region select; next cycle cpu_read_data = device data for that region, cpu_read_valid = 1.
- Level mode: kbd_valid loads scancode into held register (0 = key released); KBD_DATA reads held value, non-destructive; KBD+1 unmapped.
- FIFO mode: kbd_valid pushes if not full; push while full drops the code and sets kbd_overflow. Read of KBD_DATA pops head; empty read returns 0, no pop.
- Status word: bit15 overflow, bit14 empty, bits[7:0] count (0..KBD_FIFO_DEPTH), others 0. Read clears nothing.
- Write to KBD_STATUS (any data): flush FIFO (count 0) and clear overflow. Write to KBD_DATA: dropped, bus_error.
- Unmapped read: data 0, valid pulses, bus_error. Unmapped write: dropped, bus_error.
- cpu_read and cpu_write same cycle: both performed; read returns pre-write device value.

## Timing
- Reset (sync): cpu_read_data 0, cpu_read_valid 0, bus_error 0, kbd_overflow 0, FIFO empty, held scancode 0. ram_write/screen_write are combinational and follow inputs; bench holds cpu_write low during reset.
- Read latency exactly 1 cycle; back-to-back reads each cycle, one valid per request.
- bus_error asserts the cycle after the offending request, one cycle wide.
- Push/pop same cycle: when empty, push only (read returns 0); when full, both occur, count unchanged, no overflow.
- Flush and push same cycle: flush wins, count 0.
- Pop effect visible to next read; status read same cycle as push reports pre-push count.
- Reset mid-operation discards pending read (no valid pulse) and FIFO contents.
- FIFO pointers wrap modulo KBD_FIFO_DEPTH.

## Test plan
- Write 0x1234 to 0x0005 and 0xBEEF to 0x4001 -> ram_write then screen_write single pulses, correct addresses; reads return 0x1234, 0xBEEF one cycle later with valid.
- Level mode: kbd_valid with 0x0041, read 0x6000 twice -> 0x0041 both; kbd_valid 0 -> read 0.
- FIFO mode: push 0x41,0x42,0x43; status read -> 0x0003; three reads -> 0x41,0x42,0x43; fourth -> 0, status 0x4000.
- FIFO mode: 9 pushes depth 8 -> kbd_overflow 1, status 0x8008; write to 0x6001 -> status 0x4000, overflow 0.
- Read 0x7000, write 0x6000, write 0x8000 -> each gives one bus_error pulse; read data 0; no device strobes.
- Full FIFO push+pop same cycle -> popped head returned, count stays 8, no overflow; reset with pending read -> no valid pulse, status 0x4000.

Source files
------------

// File: rtl/hack_memory_map.sv
// hack_memory_map: Hack CPU address decode, write-strobe steering, one-cycle read
// return path, and a keyboard front end that is either a level-held scancode register
// or a pop-on-read scancode FIFO with status and sticky overflow.
module hack_memory_map #(
  parameter int DATA_WIDTH       = 16,
  parameter int RAM_ADDR_BITS    = 14,
  parameter int SCREEN_ADDR_BITS = 13,
  parameter int KBD_FIFO_DEPTH   = 8,
  parameter int KBD_MODE         = 0
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [15:0]                 cpu_address,
  input  logic [DATA_WIDTH-1:0]       cpu_write_data,
  input  logic                        cpu_write,
  input  logic                        cpu_read,
  output logic [DATA_WIDTH-1:0]       cpu_read_data,
  output logic                        cpu_read_valid,
  output logic [RAM_ADDR_BITS-1:0]    ram_address,
  output logic [DATA_WIDTH-1:0]       ram_write_data,
  output logic                        ram_write,
  input  logic [DATA_WIDTH-1:0]       ram_read_data,
  output logic [SCREEN_ADDR_BITS-1:0] screen_address,
  output logic [DATA_WIDTH-1:0]       screen_write_data,
  output logic                        screen_write,
  input  logic [DATA_WIDTH-1:0]       screen_read_data,
  input  logic [15:0]                 kbd_scancode,
  input  logic                        kbd_valid,
  output logic                        kbd_overflow,
  output logic                        bus_error
);

  localparam logic            FIFO_MODE   = (KBD_MODE != 0);
  localparam int              PW          = (KBD_FIFO_DEPTH > 1) ? $clog2(KBD_FIFO_DEPTH) : 1;
  localparam int              CW          = PW + 1;
  localparam logic [CW-1:0]   FULL_CNT    = CW'(KBD_FIFO_DEPTH);
  // 17-bit map arithmetic so a 16-bit address space never wraps the compares
  localparam logic [16:0]     SCREEN_BASE = 17'd1 << RAM_ADDR_BITS;
  localparam logic [16:0]     KBD_ADDR    = SCREEN_BASE + (17'd1 << SCREEN_ADDR_BITS);
  localparam logic [16:0]     KSTAT_ADDR  = KBD_ADDR + 17'd1;

  typedef enum logic [2:0] {
    REG_RAM    = 3'd0,
    REG_SCREEN = 3'd1,
    REG_KDATA  = 3'd2,
    REG_KSTAT  = 3'd3,
    REG_NONE   = 3'd4
  } region_e;

  region_e         region;
  logic [16:0]     addr_ext;

  region_e         region_d,    region_q;
  logic            valid_d,     valid_q;
  logic            err_d,       err_q;
  logic [DATA_WIDTH-1:0] kbd_rdata_d, kbd_rdata_q;
  logic [15:0]     held_d,      held_q;
  logic [PW-1:0]   wr_ptr_d,    wr_ptr_q;
  logic [PW-1:0]   rd_ptr_d,    rd_ptr_q;
  logic [CW-1:0]   count_d,     count_q;
  logic            ovf_d,       ovf_q;
  logic [15:0]     fifo_d [KBD_FIFO_DEPTH];
  logic [15:0]     fifo_q [KBD_FIFO_DEPTH];

  logic            fifo_empty, fifo_full, push, pop, flush, ovf_set;
  logic [15:0]     kbd_word, status_word;

  assign addr_ext          = {1'b0, cpu_address};
  assign ram_address       = cpu_address[RAM_ADDR_BITS-1:0];
  assign screen_address    = cpu_address[SCREEN_ADDR_BITS-1:0];
  assign ram_write_data    = cpu_write_data;
  assign screen_write_data = cpu_write_data;
  assign cpu_read_valid    = valid_q;
  assign bus_error         = err_q;
  assign kbd_overflow      = ovf_q;

  // Address decode into one region; the status word only exists in FIFO mode.
  always_comb begin
    region = REG_NONE;
    if (addr_ext < SCREEN_BASE) begin
      region = REG_RAM;
    end else if (addr_ext < KBD_ADDR) begin
      region = REG_SCREEN;
    end else if (addr_ext == KBD_ADDR) begin
      region = REG_KDATA;
    end else if (FIFO_MODE && (addr_ext == KSTAT_ADDR)) begin
      region = REG_KSTAT;
    end else begin
      region = REG_NONE;
    end
  end

  // Store strobes go straight to the devices so they capture on the same edge.
  always_comb begin
    ram_write    = cpu_write & (region == REG_RAM);
    screen_write = cpu_write & (region == REG_SCREEN);
  end

  // Keyboard front end: FIFO control, held scancode, and the word a load would see now.
  always_comb begin
    fifo_empty  = (count_q == {CW{1'b0}});
    fifo_full   = (count_q == FULL_CNT);
    flush       = FIFO_MODE & cpu_write & (region == REG_KSTAT);
    pop         = FIFO_MODE & cpu_read & (region == REG_KDATA) & ~fifo_empty;
    // a pop frees the head slot in the same cycle, so a full FIFO can still accept
    push        = FIFO_MODE & kbd_valid & ~flush & (~fifo_full | pop);
    ovf_set     = FIFO_MODE & kbd_valid & ~flush & fifo_full & ~pop;
    status_word = {ovf_q, fifo_empty, 6'd0, 8'(count_q)};
    if (FIFO_MODE) begin
      kbd_word = fifo_empty ? 16'd0 : fifo_q[rd_ptr_q];
    end else begin
      kbd_word = held_q;
    end

    fifo_d = fifo_q;
    if (push) begin
      fifo_d[wr_ptr_q] = kbd_scancode;
    end else begin
      fifo_d[wr_ptr_q] = fifo_q[wr_ptr_q];
    end

    if (flush) begin
      wr_ptr_d = {PW{1'b0}};
      rd_ptr_d = {PW{1'b0}};
      count_d  = {CW{1'b0}};
      ovf_d    = 1'b0;
    end else begin
      wr_ptr_d = push ? (wr_ptr_q + {{(PW-1){1'b0}}, 1'b1}) : wr_ptr_q;
      rd_ptr_d = pop  ? (rd_ptr_q + {{(PW-1){1'b0}}, 1'b1}) : rd_ptr_q;
      case ({push, pop})
        2'b10:   count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
        2'b01:   count_d = count_q - {{(CW-1){1'b0}}, 1'b1};
        default: count_d = count_q;
      endcase
      ovf_d = ovf_q | ovf_set;
    end

    if (!FIFO_MODE && kbd_valid) begin
      held_d = kbd_scancode;
    end else begin
      held_d = held_q;
    end
  end

  // Read request capture: region, valid pulse, error pulse and keyboard snapshot.
  always_comb begin
    valid_d  = cpu_read;
    region_d = cpu_read ? region : region_q;
    err_d    = (cpu_read & (region == REG_NONE)) |
               (cpu_write & ((region == REG_NONE) | (region == REG_KDATA)));
    case (region)
      REG_KDATA: kbd_rdata_d = DATA_WIDTH'(kbd_word);
      REG_KSTAT: kbd_rdata_d = DATA_WIDTH'(status_word);
      default:   kbd_rdata_d = {DATA_WIDTH{1'b0}};
    endcase
  end

  // Return data: devices answer one cycle after the address, keyboard words were snapshotted.
  always_comb begin
    if (valid_q) begin
      case (region_q)
        REG_RAM:    cpu_read_data = ram_read_data;
        REG_SCREEN: cpu_read_data = screen_read_data;
        REG_KDATA:  cpu_read_data = kbd_rdata_q;
        REG_KSTAT:  cpu_read_data = kbd_rdata_q;
        default:    cpu_read_data = {DATA_WIDTH{1'b0}};
      endcase
    end else begin
      cpu_read_data = {DATA_WIDTH{1'b0}};
    end
  end

  // Control state with synchronous reset; reset drops any pending read and empties the FIFO.
  always_ff @(posedge clock) begin
    if (reset) begin
      region_q    <= REG_NONE;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      kbd_rdata_q <= {DATA_WIDTH{1'b0}};
      held_q      <= 16'd0;
      wr_ptr_q    <= {PW{1'b0}};
      rd_ptr_q    <= {PW{1'b0}};
      count_q     <= {CW{1'b0}};
      ovf_q       <= 1'b0;
    end else begin
      region_q    <= region_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      kbd_rdata_q <= kbd_rdata_d;
      held_q      <= held_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
    end
  end

  // Scancode storage; contents are only meaningful between the pointers, so no reset.
  always_ff @(posedge clock) begin
    fifo_q <= fifo_d;
  end

endmodule

// File: tb/tb_hack_memory_map.sv
// Bench for hack_memory_map: one level-mode and one FIFO-mode instance share the CPU and
// keyboard stimulus; per-cycle expected read results are queued and checked by a monitor.
module tb_hack_memory_map;

  typedef struct packed { logic v; logic [15:0] d; logic e; } exp_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset = 1'b1, cpu_write = 1'b0, cpu_read = 1'b0, kbd_valid = 1'b0;
  logic [15:0] cpu_address = 16'd0, cpu_write_data = 16'd0, kbd_scancode = 16'd0;
  logic [15:0] ram_rd, scr_rd;

  logic [15:0] f_rdata, f_ram_wd, f_scr_wd, l_rdata, l_ram_wd, l_scr_wd;
  logic        f_valid, f_ram_we, f_scr_we, f_ovf, f_err;
  logic        l_valid, l_ram_we, l_scr_we, l_ovf, l_err;
  logic [13:0] f_ram_addr, l_ram_addr;
  logic [12:0] f_scr_addr, l_scr_addr;

  logic [15:0] ram_mem [16384];
  logic [15:0] scr_mem [8192];

  exp_t exp_f[$];
  exp_t exp_l[$];
  exp_t mon_f, mon_l;
  int   n_checks = 0;
  int   n_fail   = 0;

  hack_memory_map #(.KBD_MODE(1)) u_fifo (
    .clock(clock), .reset(reset), .cpu_address(cpu_address), .cpu_write_data(cpu_write_data),
    .cpu_write(cpu_write), .cpu_read(cpu_read), .cpu_read_data(f_rdata), .cpu_read_valid(f_valid),
    .ram_address(f_ram_addr), .ram_write_data(f_ram_wd), .ram_write(f_ram_we), .ram_read_data(ram_rd),
    .screen_address(f_scr_addr), .screen_write_data(f_scr_wd), .screen_write(f_scr_we),
    .screen_read_data(scr_rd), .kbd_scancode(kbd_scancode), .kbd_valid(kbd_valid),
    .kbd_overflow(f_ovf), .bus_error(f_err)
  );

  hack_memory_map #(.KBD_MODE(0)) u_lvl (
    .clock(clock), .reset(reset), .cpu_address(cpu_address), .cpu_write_data(cpu_write_data),
    .cpu_write(cpu_write), .cpu_read(cpu_read), .cpu_read_data(l_rdata), .cpu_read_valid(l_valid),
    .ram_address(l_ram_addr), .ram_write_data(l_ram_wd), .ram_write(l_ram_we), .ram_read_data(ram_rd),
    .screen_address(l_scr_addr), .screen_write_data(l_scr_wd), .screen_write(l_scr_we),
    .screen_read_data(scr_rd), .kbd_scancode(kbd_scancode), .kbd_valid(kbd_valid),
    .kbd_overflow(l_ovf), .bus_error(l_err)
  );

  // Synchronous RAM and screen models: read data one cycle after the address, pre-write value.
  always @(posedge clock) begin
    if (f_ram_we) ram_mem[f_ram_addr] <= f_ram_wd;
    ram_rd <= ram_mem[f_ram_addr];
    if (f_scr_we) scr_mem[f_scr_addr] <= f_scr_wd;
    scr_rd <= scr_mem[f_scr_addr];
  end

  // Scoreboard consumer: one expectation per cycle per instance, checked just after the edge.
  always @(posedge clock) begin
    #1;
    if (exp_f.size() > 0) begin
      mon_f = exp_f.pop_front();
      n_checks++;
      if (f_valid !== mon_f.v) begin n_fail++; $display("FAIL fifo_valid got %0b exp %0b t=%0t", f_valid, mon_f.v, $time); end
      n_checks++;
      if (f_err !== mon_f.e) begin n_fail++; $display("FAIL fifo_bus_error got %0b exp %0b t=%0t", f_err, mon_f.e, $time); end
      if (mon_f.v) begin
        n_checks++;
        if (f_rdata !== mon_f.d) begin n_fail++; $display("FAIL fifo_rdata got %h exp %h t=%0t", f_rdata, mon_f.d, $time); end
      end
    end
    if (exp_l.size() > 0) begin
      mon_l = exp_l.pop_front();
      n_checks++;
      if (l_valid !== mon_l.v) begin n_fail++; $display("FAIL lvl_valid got %0b exp %0b t=%0t", l_valid, mon_l.v, $time); end
      n_checks++;
      if (l_err !== mon_l.e) begin n_fail++; $display("FAIL lvl_bus_error got %0b exp %0b t=%0t", l_err, mon_l.e, $time); end
      if (mon_l.v) begin
        n_checks++;
        if (l_rdata !== mon_l.d) begin n_fail++; $display("FAIL lvl_rdata got %h exp %h t=%0t", l_rdata, mon_l.d, $time); end
      end
    end
  end

  function automatic exp_t mk(input logic v, input logic [15:0] d, input logic e);
    exp_t r;
    r.v = v; r.d = d; r.e = e;
    return r;
  endfunction

  localparam exp_t E0 = '0;

  // Drive one cycle of stimulus on the falling edge and queue what each instance must return.
  task automatic step(input logic rst, input logic [15:0] addr, input logic wr, input logic [15:0] wd,
                      input logic rd, input logic kv, input logic [15:0] kc, input exp_t ef, input exp_t el);
    @(negedge clock);
    reset = rst; cpu_address = addr; cpu_write = wr; cpu_write_data = wd;
    cpu_read = rd; kbd_valid = kv; kbd_scancode = kc;
    exp_f.push_back(ef);
    exp_l.push_back(el);
  endtask

  task automatic test_reset();
    step(1'b1, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, E0, E0);
    step(1'b1, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, E0, E0);
    @(posedge clock); #2;
    n_checks++;
    if (f_rdata !== 16'h0000 || l_rdata !== 16'h0000) begin n_fail++; $display("FAIL reset_rdata got %h/%h exp 0000", f_rdata, l_rdata); end
    n_checks++;
    if (f_ovf !== 1'b0 || l_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %0b/%0b exp 0", f_ovf, l_ovf); end
    step(1'b0, 16'h6001, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, mk(1'b1, 16'h4000, 1'b0), mk(1'b1, 16'h0000, 1'b1));
  endtask

  task automatic test_ram_screen();
    step(1'b0, 16'h0005, 1'b1, 16'h1234, 1'b0, 1'b0, 16'h0000, E0, E0);
    #1;
    n_checks++;
    if (f_ram_we !== 1'b1 || f_scr_we !== 1'b0 || f_ram_addr !== 14'h0005 || l_ram_we !== 1'b1)
      begin n_fail++; $display("FAIL ram_strobe got we=%0b swe=%0b addr=%h exp 1 0 0005", f_ram_we, f_scr_we, f_ram_addr); end
    step(1'b0, 16'h4001, 1'b1, 16'hBEEF, 1'b0, 1'b0, 16'h0000, E0, E0);
    #1;
    n_checks++;
    if (f_scr_we !== 1'b1 || f_ram_we !== 1'b0 || f_scr_addr !== 13'h0001 || f_scr_wd !== 16'hBEEF)
      begin n_fail++; $display("FAIL screen_strobe got swe=%0b we=%0b addr=%h exp 1 0 0001", f_scr_we, f_ram_we, f_scr_addr); end
    step(1'b0, 16'h0005, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, mk(1'b1, 16'h1234, 1'b0), mk(1'b1, 16'h1234, 1'b0));
    step(1'b0, 16'h4001, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, mk(1'b1, 16'hBEEF, 1'b0), mk(1'b1, 16'hBEEF, 1'b0));
    // load and store together: load sees the old word
    step(1'b0, 16'h0005, 1'b1, 16'h5555, 1'b1, 1'b0, 16'h0000, mk(1'b1, 16'h1234, 1'b0), mk(1'b1, 16'h1234, 1'b0));
    step(1'b0, 16'h0005, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, mk(1'b1, 16'h5555, 1'b0), mk(1'b1, 16'h5555, 1'b0));
    step(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, E0, E0);
  endtask

  task automatic test_errors();
    step(1'b0, 16'h7000, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, mk(1'b1, 16'h0000, 1'b1), mk(1'b1, 16'h0000, 1'b1));
    step(1'b0, 16'h6000, 1'b1, 16'hAAAA, 1'b0, 1'b0, 16'h0000, mk(1'b0, 16'h0000, 1'b1), mk(1'b0, 16'h0000, 1'b1));
    #1;
    n_checks++;
    if (f_ram_we !== 1'b0 || f_scr_we !== 1'b0) begin n_fail++; $display("FAIL kbd_write_strobe got %0b%0b exp 00", f_ram_we, f_scr_we); end
    step(1'b0, 16'h8000, 1'b1, 16'hAAAA, 1'b0, 1'b0, 16'h0000, mk(1'b0, 16'h0000, 1'b1), mk(1'b0, 16'h0000, 1'b1));
    #1;
    n_checks++;
    if (f_ram_we !== 1'b0 || f_scr_we !== 1'b0 || l_ram_we !== 1'b0) begin n_fail++; $display("FAIL unmapped_strobe got %0b%0b exp 00", f_ram_we, f_scr_we); end
    step(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, E0, E0);
  endtask

  task automatic test_level();
    step(1'b1, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, E0, E0);
    step(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0041, E0, E0);
    step(1'b0, 16'h6000, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, mk(1'b1, 16'h0041, 1'b0), mk(1'b1, 16'h0041, 1'b0));
    step(1'b0, 16'h6000, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, mk(1'b1, 16'h0000, 1'b0), mk(1'b1, 16'h0041, 1'b0));
    step(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, E0, E0);
    step(1'b0, 16'h6000, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, mk(1'b1, 16'h0000, 1'b0), mk(1'b1, 16'h0000, 1'b0));
    step(1'b0, 16'h6001, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, mk(1'b1, 16'h4000, 1'b0), mk(1'b1, 16'h0000, 1'b1));
  endtask

  task automatic test_fifo();
    logic [15:0] codes [3];
    codes[0] = 16'h0041; codes[1] = 16'h0042; codes[2] = 16'h0043;
    step(1'b1, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, E0, E0);
    for (int i = 0; i < 3; i++)
      step(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, codes[i], E0, E0);
    step(1'b0, 16'h6001, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, mk(1'b1, 16'h0003, 1'b0), mk(1'b1, 16'h0000, 1'b1));
    for (int i = 0; i < 3; i++)
      step(1'b0, 16'h6000, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, mk(1'b1, codes[i], 1'b0), mk(1'b1, 16'h0043, 1'b0));
    step(1'b0, 16'h6000, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, mk(1'b1, 16'h0000, 1'b0), mk(1'b1, 16'h0043, 1'b0));
    step(1'b0, 16'h6001, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, mk(1'b1, 16'h4000, 1'b0), mk(1'b1, 16'h0000, 1'b1));
  endtask

  task automatic test_overflow();
    logic [15:0] code;
    step(1'b1, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, E0, E0);
    for (int i = 0; i < 8; i++) begin
      code = 16'h0050 + 16'(i);
      step(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, code, E0, E0);
    end
    // full: push and pop together keep the count and raise no overflow
    step(1'b0, 16'h6000, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0099, mk(1'b1, 16'h0050, 1'b0), mk(1'b1, 16'h0057, 1'b0));
    step(1'b0, 16'h6001, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, mk(1'b1, 16'h0008, 1'b0), mk(1'b1, 16'h0000, 1'b1));
    step(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h00AA, E0, E0);
    @(posedge clock); #2;
    n_checks++;
    if (f_ovf !== 1'b1 || l_ovf !== 1'b0) begin n_fail++; $display("FAIL overflow_set got %0b/%0b exp 1/0", f_ovf, l_ovf); end
    step(1'b0, 16'h6001, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, mk(1'b1, 16'h8008, 1'b0), mk(1'b1, 16'h0000, 1'b1));
    for (int i = 0; i < 8; i++) begin
      code = (i == 7) ? 16'h0099 : (16'h0051 + 16'(i));
      step(1'b0, 16'h6000, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, mk(1'b1, code, 1'b0), mk(1'b1, 16'h00AA, 1'b0));
    end
    step(1'b0, 16'h6001, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, mk(1'b1, 16'hC000, 1'b0), mk(1'b1, 16'h0000, 1'b1));
    // flush with a simultaneous push: flush wins
    step(1'b0, 16'h6001, 1'b1, 16'h1111, 1'b0, 1'b1, 16'h00BB, E0, mk(1'b0, 16'h0000, 1'b1));
    @(posedge clock); #2;
    n_checks++;
    if (f_ovf !== 1'b0) begin n_fail++; $display("FAIL overflow_clear got %0b exp 0", f_ovf); end
    step(1'b0, 16'h6001, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, mk(1'b1, 16'h4000, 1'b0), mk(1'b1, 16'h0000, 1'b1));
  endtask

  task automatic test_reset_pending();
    step(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0011, E0, E0);
    step(1'b1, 16'h6000, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, E0, E0);
    step(1'b0, 16'h6001, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, mk(1'b1, 16'h4000, 1'b0), mk(1'b1, 16'h0000, 1'b1));
    step(1'b0, 16'h6000, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, mk(1'b1, 16'h0000, 1'b0), mk(1'b1, 16'h0000, 1'b0));
    step(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, E0, E0);
  endtask

  initial begin
    test_reset();
    test_ram_screen();
    test_errors();
    test_level();
    test_fifo();
    test_overflow();
    test_reset_pending();
    step(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, E0, E0);
    repeat (2) @(posedge clock);
    #3;
    n_checks++;
    if (exp_f.size() != 0 || exp_l.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain got %0d/%0d exp 0/0", exp_f.size(), exp_l.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
